// File: rtl/fft1024_twiddle_seq.sv
// fft1024_twiddle_seq
// Address/twiddle sequencer for a 1024-point radix-2 DIT FFT. Walks every
// stage and butterfly, drives the twiddle LUT address, and presents one
// butterfly record per handshake to the datapath.
// Optional build macro: TW_CONJ_EN adds the Inverse input, which selects
// conjugated twiddles (imag negated, saturating) for an inverse transform.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; counters at zero, no record presented
// RUN   | loading butterfly records whenever the output slot is free
// DRAIN | final record loaded; hold it until accepted, then pulse done
module fft1024_twiddle_seq #(
  parameter int LOG2N = 10,
  parameter int TW_W  = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
`ifdef TW_CONJ_EN
  input  logic                 Inverse,
`endif
  output logic [LOG2N-1:0]     lut_n,
  input  logic [2*TW_W-1:0]    lut_tw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG2N-1:0]     addr_a,
  output logic [LOG2N-1:0]     addr_b,
  output logic [LOG2N-2:0]     tw_idx,
  output logic [TW_W-1:0]      tw_real,
  output logic [TW_W-1:0]      tw_imag,
  output logic [3:0]           stage,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0]      LAST_STAGE = 4'(LOG2N - 1);
  localparam logic [TW_W-1:0] TW_MIN     = {1'b1, {(TW_W-1){1'b0}}};
  localparam logic [TW_W-1:0] TW_MAX     = {1'b0, {(TW_W-1){1'b1}}};

  state_t           state_q, state_d;
  logic [3:0]       s_q;
  logic [LOG2N-2:0] b_q;

  logic             load;
  logic             start_go;
  logic             finish;
  logic             last_bfly;

  logic [LOG2N-1:0] b_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] a_nx;
  logic [LOG2N-1:0] bb_nx;
  logic [LOG2N-2:0] tw_nx;
  logic [3:0]       tw_shift;

  logic [TW_W-1:0]  lut_re;
  logic [TW_W-1:0]  lut_im;
  logic [TW_W-1:0]  im_sel;

  assign last_bfly = (s_q == LAST_STAGE) && (b_q == '1);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    start_go = 1'b0;
    finish   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          start_go = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        load = !out_valid || out_ready;
        if (load && last_bfly) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly index math for the counter position (s_q, b_q)
  always_comb begin
    b_ext    = {1'b0, b_q};
    span     = {{(LOG2N-1){1'b0}}, 1'b1} << s_q;
    pos      = b_ext & (span - 1'b1);
    grp      = b_ext >> s_q;
    a_nx     = (grp << (s_q + 4'd1)) | pos;
    bb_nx    = a_nx + span;
    tw_shift = LAST_STAGE - s_q;
    tw_nx    = pos[LOG2N-2:0] << tw_shift;
  end

  // The LUT is addressed by the butterfly that the next load will capture,
  // so its output is ready in the same cycle as the load
  assign lut_n = {1'b0, tw_nx};

  // Stage/butterfly counters; they only move on a load, so lut_n is frozen
  // during backpressure
  always_ff @(posedge Clk) begin
    if (Reset || start_go) begin
      s_q <= '0;
      b_q <= '0;
    end else if (load) begin
      if (last_bfly) begin
        s_q <= '0;
        b_q <= '0;
      end else if (b_q == '1) begin
        s_q <= s_q + 4'd1;
        b_q <= '0;
      end else begin
        b_q <= b_q + 1'b1;
      end
    end
  end

  assign lut_re = lut_tw[2*TW_W-1:TW_W];
  assign lut_im = lut_tw[TW_W-1:0];

`ifdef TW_CONJ_EN
  logic inv_q;

  // Transform direction is latched at Start and fixed for the whole sequence
  always_ff @(posedge Clk) begin
    if (Reset)         inv_q <= 1'b0;
    else if (start_go) inv_q <= Inverse;
  end

  // Conjugate: negate imag, clamping the one value with no positive twin
  always_comb begin
    im_sel = lut_im;
    if (inv_q) begin
      if (lut_im == TW_MIN) im_sel = TW_MAX;
      else                  im_sel = -lut_im;
    end
  end
`else
  assign im_sel = lut_im;
`endif

  // Output record register and handshake flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tw_idx    <= '0;
      tw_real   <= '0;
      tw_imag   <= '0;
      stage     <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        out_valid <= 1'b1;
        addr_a    <= a_nx;
        addr_b    <= bb_nx;
        tw_idx    <= tw_nx;
        tw_real   <= lut_re;
        tw_imag   <= im_sel;
        stage     <= s_q;
      end else if (finish) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fft1024_twiddle_seq.sv
// tb_fft1024_twiddle_seq
// Scoreboard bench for the FFT twiddle sequencer. A nested-loop DIT model
// fills the expected queue at Start; a negedge monitor pops on every
// handshake. Build with TW_CONJ_EN to include the inverse-twiddle sequence.
module tb_fft1024_twiddle_seq;

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic [8:0]  n;
    logic [3:0]  s;
    logic [15:0] re;
    logic [15:0] im;
  } rec_t;

  logic        Clk;
  logic        Reset;
  logic        Start;
`ifdef TW_CONJ_EN
  logic        Inverse;
`endif
  logic [9:0]  lut_n;
  logic [31:0] lut_tw;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  addr_a;
  logic [9:0]  addr_b;
  logic [8:0]  tw_idx;
  logic [15:0] tw_real;
  logic [15:0] tw_imag;
  logic [3:0]  stage;
  logic        busy;
  logic        done;

  logic [31:0] lut_mem [1024];
  rec_t        q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          rec_idx   = 0;
  int          done_cnt  = 0;
  bit          rnd_ready = 0;
  bit          seq_inv   = 0;

  fft1024_twiddle_seq dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
`ifdef TW_CONJ_EN
    .Inverse   (Inverse),
`endif
    .lut_n     (lut_n),
    .lut_tw    (lut_tw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .tw_real   (tw_real),
    .tw_imag   (tw_imag),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
  );

  // Combinational LUT model
  assign lut_tw = lut_mem[lut_n];

  // Clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] conj_im(input logic [15:0] im, input bit inv);
    if (!inv) return im;
    if (im == 16'h8000) return 16'h7fff;
    return 16'(0 - int'($signed(im)));
  endfunction

  // Reference: classic DIT loops (stage, group base, position in group)
  task automatic push_expected(input bit inv);
    rec_t r;
    for (int s = 0; s < 10; s++) begin
      int span = 1 << s;
      for (int base = 0; base < 1024; base += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          r.s  = 4'(s);
          r.a  = 10'(base + p);
          r.b  = 10'(base + p + span);
          r.n  = 9'(p * (512 / span));
          r.re = lut_mem[r.n][31:16];
          r.im = conj_im(lut_mem[r.n][15:0], inv);
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic fill_lut();
    for (int i = 0; i < 1024; i++) lut_mem[i] = $urandom;
    lut_mem[5][15:0]   = 16'h8000;
    lut_mem[256][15:0] = 16'h8001;
  endtask

  // Ready driver: all-ones or pseudo-random with ~1/3 stall
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on handshake, hold stability, done accounting
  logic        hold = 0;
  logic [63:0] held_key;
  logic [31:0] held_tw;
  logic [9:0]  held_n;
  always @(negedge Clk) begin
    rec_t e;
    if (Reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_rec", {31'd0, addr_a, addr_b, tw_idx, stage}, held_key);
        chk("hold_tw", 64'({tw_real, tw_imag}), 64'(held_tw));
        chk("hold_lut_n", 64'(lut_n), 64'(held_n));
        hold = 0;
      end
      if (out_valid && !out_ready) begin
        hold     = 1;
        held_key = {31'd0, addr_a, addr_b, tw_idx, stage};
        held_tw  = {tw_real, tw_imag};
        held_n   = lut_n;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_record: got record a=%0d b=%0d with 0 expected pending", addr_a, addr_b);
        end else begin
          e = q.pop_front();
          chk("rec_a", 64'(addr_a), 64'(e.a));
          chk("rec_b", 64'(addr_b), 64'(e.b));
          chk("rec_n", 64'(tw_idx), 64'(e.n));
          chk("rec_s", 64'(stage), 64'(e.s));
          chk("rec_re", 64'(tw_real), 64'(e.re));
          chk("rec_im", 64'(tw_imag), 64'(e.im));
          if (rec_idx == 0)
            chk("rec0", {31'd0, addr_a, addr_b, tw_idx, stage}, {31'd0, 10'd0, 10'd1, 9'd0, 4'd0});
          if (rec_idx == 1)
            chk("rec1", {31'd0, addr_a, addr_b, tw_idx, stage}, {31'd0, 10'd2, 10'd3, 9'd0, 4'd0});
          if (rec_idx == 513)
            chk("rec513", {31'd0, addr_a, addr_b, tw_idx, stage}, {31'd0, 10'd1, 10'd3, 9'd256, 4'd1});
          if (rec_idx == 5119)
            chk("rec5119", {31'd0, addr_a, addr_b, tw_idx, stage}, {31'd0, 10'd511, 10'd1023, 9'd511, 4'd9});
          if (seq_inv && e.n == 9'd5)   chk("conj_min", 64'(tw_imag), 64'h7fff);
          if (seq_inv && e.n == 9'd256) chk("conj_m32767", 64'(tw_imag), 64'h7fff);
          if (q.size() > 0) chk("lut_n_next", 64'(lut_n), 64'(q[0].n));
        end
        rec_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("done_q_empty", 64'(q.size()), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_valid", 64'(out_valid), 64'd0);
      end
    end
  end

  task automatic run_seq(input bit rnd, input bit pulse_start, input bit inv, input bit timing);
    int cnt;
    int d0;
    bit got;
    fill_lut();
    q.delete();
    push_expected(inv);
    rec_idx   = 0;
    seq_inv   = inv;
    d0        = done_cnt;
    rnd_ready = rnd;
    @(posedge Clk);
    #1;
    Start = 1'b1;
`ifdef TW_CONJ_EN
    Inverse = inv;
`endif
    @(posedge Clk);
    #1;
    Start = 1'b0;
`ifdef TW_CONJ_EN
    Inverse = ~inv;
`endif
    if (timing) begin
      chk("lat_pre_valid", 64'(out_valid), 64'd0);
      chk("lat_pre_busy", 64'(busy), 64'd1);
    end
    cnt = 0;
    got = 0;
    while (cnt < 20000) begin
      @(posedge Clk);
      #1;
      cnt++;
      if (timing && cnt == 1) chk("lat_first_valid", 64'(out_valid), 64'd1);
      if (done) begin
        Start = 1'b0;
        got   = 1;
        break;
      end
      Start = pulse_start ? (($urandom_range(0, 7) == 0) || rec_idx >= 5119) : 1'b0;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles, required one", cnt);
    end
    Start = 1'b0;
    if (timing) begin
      chk("done_edge", 64'(cnt), 64'd5121);
      chk("done_edge_busy", 64'(busy), 64'd0);
    end
    @(posedge Clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    repeat (4) begin
      @(posedge Clk);
      #1;
      chk("post_idle_valid", 64'(out_valid), 64'd0);
    end
    chk("seq_done_count", 64'(done_cnt - d0), 64'd1);
    chk("seq_rec_count", 64'(rec_idx), 64'd5120);
    chk("seq_q_empty", 64'(q.size()), 64'd0);
    rnd_ready = 0;
    seq_inv   = 0;
`ifdef TW_CONJ_EN
    Inverse = 1'b0;
`endif
  endtask

  task automatic reset_mid_seq();
    int cnt;
    int d0;
    fill_lut();
    q.delete();
    push_expected(1'b0);
    rec_idx   = 0;
    d0        = done_cnt;
    rnd_ready = 1;
    @(posedge Clk);
    #1;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    cnt = 0;
    while (cnt < 20000 && rec_idx < 2000) begin
      @(posedge Clk);
      #1;
      cnt++;
    end
    checks++;
    if (rec_idx < 2000) begin
      errors++;
      $display("FAIL mid_timeout: got %0d records, required 2000", rec_idx);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_addr", {44'd0, addr_a, addr_b}, 64'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    rnd_ready = 0;
    q.delete();
    @(posedge Clk);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);
  endtask

  // Main stimulus
  initial begin
    Reset = 1'b1;
    Start = 1'b1;
`ifdef TW_CONJ_EN
    Inverse = 1'b0;
`endif
    fill_lut();
    repeat (3) begin
      @(posedge Clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rec", {31'd0, addr_a, addr_b, tw_idx, stage}, 64'd0);
      chk("rst_tw", 64'({tw_real, tw_imag}), 64'd0);
    end
    Reset = 1'b0;
    Start = 1'b0;
    @(posedge Clk);
    #1;
    chk("idle_after_rst_busy", 64'(busy), 64'd0);
    chk("idle_after_rst_valid", 64'(out_valid), 64'd0);

    run_seq(1'b0, 1'b0, 1'b0, 1'b1);
    run_seq(1'b1, 1'b1, 1'b0, 1'b0);
    reset_mid_seq();
    run_seq(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TW_CONJ_EN
    run_seq(1'b0, 1'b0, 1'b1, 1'b0);
    run_seq(1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
